// File: rtl/seg_page_scan.sv
// rtl/seg_page_scan.sv - paged seven-segment digit scanner with tear-free page switching (optional blink: SEG_PAGE_BLINK_EN)
module seg_page_scan #(
    parameter int DIGITS        = 6,
    parameter int PAGES         = 2,
    parameter int SCAN_DIV      = 5000,
    parameter int ROTATE_FRAMES = 200,
    parameter int BLINK_FRAMES  = 100,
    localparam int PW           = $clog2(PAGES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PAGES*DIGITS*7-1:0] i_page_seg,
    input  logic [PAGES*DIGITS-1:0]   i_page_dp,
    input  logic [PW-1:0]             i_page_sel,
    input  logic                      i_auto,
    input  logic [DIGITS-1:0]         i_blink_mask,
    output logic [6:0]                o_seg,
    output logic                      o_seg_dp,
    output logic [DIGITS-1:0]         o_seg_enb,
    output logic [PW-1:0]             o_page,
    output logic                      o_frame
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int FW = $clog2(ROTATE_FRAMES + 1);

    logic [DW-1:0]     div_q;
    logic [IW-1:0]     dig_q;
    logic [PW-1:0]     page_q;
    logic [FW-1:0]     rot_q;
    logic              auto_q;
    logic              tick;
    logic              frame_end;
    logic              auto_rise;
    logic [PW-1:0]     page_nx;
    logic [6:0]        seg_nx;
    logic              dp_nx;
    logic [DIGITS-1:0] enb_nx;

    assign tick      = (div_q == DW'(SCAN_DIV - 1));
    assign frame_end = tick && (dig_q == IW'(DIGITS - 1));
    assign auto_rise = i_auto && !auto_q;

    // Page for the next frame; only committed at frame_end so a frame never mixes pages.
    always_comb begin
        page_nx = page_q;
        if (!i_auto) begin
            if (int'(i_page_sel) < PAGES)
                page_nx = i_page_sel;
        end else if (!auto_rise && rot_q == FW'(ROTATE_FRAMES - 1)) begin
            page_nx = (page_q == PW'(PAGES - 1)) ? '0 : page_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            dig_q  <= '0;
            page_q <= '0;
            rot_q  <= '0;
            auto_q <= 1'b0;
        end else begin
            auto_q <= i_auto;
            div_q  <= tick ? '0 : div_q + 1'b1;
            if (tick)
                dig_q <= (dig_q == IW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
            if (auto_rise)
                rot_q <= '0;
            else if (frame_end && i_auto)
                rot_q <= (rot_q == FW'(ROTATE_FRAMES - 1)) ? '0 : rot_q + 1'b1;
            if (frame_end)
                page_q <= page_nx;
        end
    end

    always_comb begin
        seg_nx = '0;
        dp_nx  = 1'b0;
        enb_nx = '1;
        for (int p = 0; p < PAGES; p++) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (page_q == PW'(p) && dig_q == IW'(k)) begin
                    seg_nx = i_page_seg[(p*DIGITS + k)*7 +: 7];
                    dp_nx  = i_page_dp[p*DIGITS + k];
                end
            end
        end
        for (int k = 0; k < DIGITS; k++)
            enb_nx[k] = (dig_q != IW'(k));
    end

`ifdef SEG_PAGE_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] blink_q;
    logic          phase_on_q;
    logic          blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q    <= '0;
            phase_on_q <= 1'b1;
        end else if (frame_end) begin
            if (blink_q == BW'(BLINK_FRAMES - 1)) begin
                blink_q    <= '0;
                phase_on_q <= ~phase_on_q;
            end else begin
                blink_q <= blink_q + 1'b1;
            end
        end
    end

    always_comb begin
        blank = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            if (dig_q == IW'(k) && i_blink_mask[k] && !phase_on_q)
                blank = 1'b1;
    end
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_blink_mask;
    assign unused_blink_mask = ^i_blink_mask;
`endif

    // Outputs lag the scan state by one cycle; o_page is delayed too so it lines up with digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_seg     <= 7'h00;
            o_seg_dp  <= 1'b0;
            o_seg_enb <= '1;
            o_page    <= '0;
            o_frame   <= 1'b0;
        end else begin
            o_seg    <= seg_nx;
            o_seg_dp <= dp_nx;
            o_page   <= page_q;
            o_frame  <= frame_end;
`ifdef SEG_PAGE_BLINK_EN
            // Blank decision is latched at slot start, so mask edits apply from the next slot.
            if (div_q == '0)
                o_seg_enb <= blank ? '1 : enb_nx;
`else
            o_seg_enb <= enb_nx;
`endif
        end
    end

endmodule
